ram_port_arbiter: RTL and testbench

Shares one single-port 4096x32 SoC RAM macro between NUM_REQ bus requesters, e.g. core data port (req 0) and boot loader / debug loader (req 1).
- Round-robin arbitration with an optional exclusive lock for multi-beat sequences such as boot image copy.
- Drives the macro's active-low CEB/WEB/BWEB pins.
- Returns read data and response strobes to the granted requester with fixed 1-cycle latency.

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/ram_port_arbiter_rr_arbiter.sv | 52 +++++
 rtl/ram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Lock FSM encoding, macro geometry and byte-lane write-mask conversion.
package ram_arb_pkg;

    localparam int MEM_WORDS = 4096;
    localparam int ADDR_W    = $clog2(MEM_WORDS);
    localparam int DATA_W    = 32;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } lock_state_e;

    // One byte lane of the macro's active-low bit write enable.
    function automatic logic [7:0] be_to_bweb(input logic wr, input logic be);
        return {8{~(wr & be)}};
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin grant: combinational priority scan starting at rr_ptr, wrapping.
// Zero latency; the pointer only advances when adv_i is asserted with a grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_i,
    input  logic                                     adv_i,
    output logic [NUM_REQ-1:0]                       gnt_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx_o
);
    import ram_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;

    always_comb begin : scan
        int   idx;
        logic found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv_i && (|gnt_o)) begin
            rr_ptr_d = (gnt_idx_o == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM macro among NUM_REQ requesters, round-robin with exclusive lock.
// Grant and macro drive are combinational; response strobe/read data follow 1 cycle later.
module ram_port_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = ram_arb_pkg::ADDR_W,
    parameter  int DATA_W  = ram_arb_pkg::DATA_W,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0]        excl_i,
    input  logic [NUM_REQ*BE_W-1:0]   be_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      locked_o,
    output logic                      mem_ceb,
    output logic                      mem_web,
    output logic [DATA_W-1:0]         mem_bweb,
    output logic [ADDR_W-1:0]         mem_a,
    output logic [DATA_W-1:0]         mem_d,
    input  logic [DATA_W-1:0]         mem_q
);
    import ram_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    lock_state_e          lock_state_q;
    logic [PTR_W-1:0]     lock_owner_q;
    logic [NUM_REQ-1:0]   rvalid_q;
    logic                 resp_is_read_q;

    logic [NUM_REQ-1:0]   req_m;
    logic [NUM_REQ-1:0]   gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic                 adv_ptr;
    logic                 we_g;
    logic                 excl_g;
    logic [BE_W-1:0]      be_g;
    logic [ADDR_W-1:0]    addr_g;
    logic [DATA_W-1:0]    wdata_g;

    // While locked only the owner may compete; reset also silences all grants.
    always_comb begin
        req_m = req_i & {NUM_REQ{rst_n}};
        for (int r = 0; r < NUM_REQ; r++) begin
            if (lock_state_q == ARB_LOCKED && PTR_W'(r) != lock_owner_q) begin
                req_m[r] = 1'b0;
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_m),
        .adv_i     (adv_ptr),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign gnt_any = |gnt;
    assign gnt_o   = gnt;

    always_comb begin
        we_g    = 1'b0;
        excl_g  = 1'b0;
        be_g    = '0;
        addr_g  = '0;
        wdata_g = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                we_g    = we_i[r];
                excl_g  = excl_i[r];
                be_g    = be_i[r*BE_W +: BE_W];
                addr_g  = addr_i[r*ADDR_W +: ADDR_W];
                wdata_g = wdata_i[r*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer stays frozen across locked beats and moves again on the release beat.
    assign adv_ptr = gnt_any && ((lock_state_q == ARB_UNLOCKED) || !excl_g);

    assign mem_ceb = ~gnt_any;
    assign mem_web = ~(gnt_any & we_g);
    assign mem_a   = addr_g;
    assign mem_d   = wdata_g;

    always_comb begin
        mem_bweb = '1;
        for (int i = 0; i < BE_W; i++) begin
            mem_bweb[8*i +: 8] = be_to_bweb(gnt_any & we_g, be_g[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_q   <= ARB_UNLOCKED;
            lock_owner_q   <= '0;
            rvalid_q       <= '0;
            resp_is_read_q <= 1'b0;
        end else begin
            rvalid_q       <= gnt;
            resp_is_read_q <= gnt_any & ~we_g;
            case (lock_state_q)
                ARB_UNLOCKED: begin
                    if (gnt_any && excl_g) begin
                        lock_state_q <= ARB_LOCKED;
                        lock_owner_q <= gnt_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (gnt_any && !excl_g) begin
                        lock_state_q <= ARB_UNLOCKED;
                    end
                end
                default: lock_state_q <= ARB_UNLOCKED;
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign locked_o = (lock_state_q == ARB_LOCKED);
    assign rdata_o  = resp_is_read_q ? mem_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: per-requester op queues, behavioural macro, response scoreboard.
module tb_ram_port_arbiter;

    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_i, we_i, excl_i;
    logic [NREQ*4-1:0] be_i;
    logic [NREQ*12-1:0] addr_i;
    logic [NREQ*32-1:0] wdata_i;
    logic [NREQ-1:0]   gnt_o, rvalid_o;
    logic [31:0]       rdata_o;
    logic              locked_o, mem_ceb, mem_web;
    logic [31:0]       mem_bweb, mem_d, mem_q;
    logic [11:0]       mem_a;

    ram_port_arbiter #(.NUM_REQ(NREQ), .ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .excl_i(excl_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .locked_o(locked_o),
        .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_bweb(mem_bweb),
        .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) ram[mem_a] <= (ram[mem_a] & mem_bweb) | (mem_d & ~mem_bweb);
            else          mem_q <= ram[mem_a];
        end
    end

    typedef struct packed {
        logic        we;
        logic        excl;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic        rd;
        logic        known;
        logic [31:0] data;
    } sb_t;

    op_t         ops [NREQ][$];
    sb_t         sb [$];
    int          gnt_log [$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rdata;
    int          m_ptr, m_owner;
    bit          m_locked;
    int          checks, failures;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_op(input int r, input logic we, input logic excl, input logic [3:0] be,
                           input logic [11:0] addr, input logic [31:0] data);
        op_t op;
        op = '{we: we, excl: excl, be: be, addr: addr, data: data};
        ops[r].push_back(op);
    endtask

    task automatic drive();
        op_t op;
        for (int r = 0; r < NREQ; r++) begin
            if (ops[r].size() > 0) begin
                op = ops[r][0];
                req_i[r] = 1'b1;
                we_i[r] = op.we;
                excl_i[r] = op.excl;
                be_i[r*4 +: 4] = op.be;
                addr_i[r*12 +: 12] = op.addr;
                wdata_i[r*32 +: 32] = op.data;
            end else begin
                req_i[r] = 1'b0;
                we_i[r] = 1'b0;
                excl_i[r] = 1'b0;
            end
        end
    endtask

    task automatic check_cycle();
        sb_t e;
        op_t op;
        int g, c;
        logic [NREQ-1:0] exp_gnt;
        logic [31:0] mask;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid", 32'(rvalid_o), 32'(2'b01 << e.idx));
            if (e.rd && e.known) chk("rdata", rdata_o, e.data);
            if (e.rd) last_rdata = rdata_o;
        end else begin
            chk("rvalid_idle", 32'(rvalid_o), 32'd0);
        end
        if (gnt_o == 2'b01) gnt_log.push_back(0);
        else if (gnt_o == 2'b10) gnt_log.push_back(1);
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            c = (m_ptr + i) % NREQ;
            if (g < 0 && ops[c].size() > 0 && (!m_locked || c == m_owner)) g = c;
        end
        exp_gnt = (g < 0) ? '0 : NREQ'(1 << g);
        chk("gnt", 32'(gnt_o), 32'(exp_gnt));
        chk("locked", 32'(locked_o), 32'(m_locked));
        chk("mem_ceb", 32'(mem_ceb), 32'(g < 0));
        if (g >= 0) begin
            op = ops[g].pop_front();
            chk("mem_a", 32'(mem_a), 32'(op.addr));
            chk("mem_web", 32'(mem_web), 32'(!op.we));
            if (op.we) begin
                mask = '0;
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{op.be[b]}};
                chk("mem_bweb", mem_bweb, ~mask);
                chk("mem_d", mem_d, op.data);
                if (ref_mem.exists(int'(op.addr)))
                    ref_mem[int'(op.addr)] = (ref_mem[int'(op.addr)] & ~mask) | (op.data & mask);
                else if (mask == 32'hFFFF_FFFF)
                    ref_mem[int'(op.addr)] = op.data;
                sb.push_back('{idx: 2'(g), rd: 1'b0, known: 1'b0, data: 32'd0});
            end else begin
                chk("mem_bweb_rd", mem_bweb, 32'hFFFF_FFFF);
                if (ref_mem.exists(int'(op.addr)))
                    sb.push_back('{idx: 2'(g), rd: 1'b1, known: 1'b1, data: ref_mem[int'(op.addr)]});
                else
                    sb.push_back('{idx: 2'(g), rd: 1'b1, known: 1'b0, data: 32'd0});
            end
            if (!m_locked) begin
                m_ptr = (g + 1) % NREQ;
                if (op.excl) begin
                    m_locked = 1'b1;
                    m_owner = g;
                end
            end else if (!op.excl) begin
                m_locked = 1'b0;
                m_ptr = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (ops[0].size() > 0 || ops[1].size() > 0 || sb.size() > 0) begin
            tick();
            n++;
            if (n > budget) begin
                chk("timeout", 32'd1, 32'd0);
                ops[0].delete();
                ops[1].delete();
                sb.delete();
                break;
            end
        end
    endtask

    task automatic chk_log(input string tag, input int exp0, input int exp1, input int exp2,
                           input int exp3, input int n);
        int exp_arr [4];
        exp_arr = '{exp0, exp1, exp2, exp3};
        chk({tag, "_len"}, 32'(gnt_log.size()), 32'(n));
        for (int i = 0; i < n && i < gnt_log.size(); i++)
            chk(tag, 32'(gnt_log[i]), 32'(exp_arr[i]));
        gnt_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        m_ptr = 0; m_owner = 0; m_locked = 1'b0;
        last_rdata = '0;
        rst_n = 1'b0;
        req_i = '0; we_i = '0; excl_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_ceb", 32'(mem_ceb), 32'd1);
        chk("rst_web", 32'(mem_web), 32'd1);
        chk("rst_bweb", mem_bweb, 32'hFFFF_FFFF);
        req_i = 2'b11;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        req_i = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // contention from rr_ptr=0
        push_op(0, 1'b1, 1'b0, 4'hF, 12'h100, 32'h0000_A000);
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h100, 32'h0);
        push_op(1, 1'b1, 1'b0, 4'hF, 12'h200, 32'h0000_B000);
        push_op(1, 1'b0, 1'b0, 4'hF, 12'h200, 32'h0);
        run_until_empty(20);
        chk_log("cont_order", 0, 1, 0, 1, 4);

        // read after write, then a be=0 write that must leave memory untouched
        push_op(0, 1'b1, 1'b0, 4'hF, 12'h010, 32'hDEAD_BEEF);
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h010, 32'h0);
        run_until_empty(20);
        chk("raw_readback", last_rdata, 32'hDEAD_BEEF);
        push_op(0, 1'b1, 1'b0, 4'h0, 12'h010, 32'h1234_5678);
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h010, 32'h0);
        run_until_empty(20);
        chk("be0_readback", last_rdata, 32'hDEAD_BEEF);
        gnt_log.delete();

        // byte write
        push_op(0, 1'b1, 1'b0, 4'hF, 12'h020, 32'h1122_3344);
        run_until_empty(20);
        push_op(1, 1'b1, 1'b0, 4'b0101, 12'h020, 32'hAABB_CCDD);
        push_op(1, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0);
        run_until_empty(20);
        chk("bw_readback", last_rdata, 32'h11BB_33DD);
        gnt_log.delete();

        // exclusive lock by req1, req0 arrives after beat 1
        push_op(1, 1'b1, 1'b1, 4'hF, 12'h300, 32'h0000_0301);
        push_op(1, 1'b1, 1'b1, 4'hF, 12'h301, 32'h0000_0302);
        push_op(1, 1'b0, 1'b0, 4'hF, 12'h300, 32'h0);
        tick();
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h301, 32'h0);
        run_until_empty(20);
        chk_log("lock_order", 1, 1, 1, 0, 4);

        // idle bus leaves rr_ptr at 1
        repeat (10) tick();
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h010, 32'h0);
        push_op(1, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0);
        run_until_empty(20);
        chk_log("idle_order", 1, 0, 0, 0, 2);

        // reset in the cycle after a locked read grant
        push_op(0, 1'b1, 1'b1, 4'hF, 12'h040, 32'hCAFE_F00D);
        push_op(0, 1'b0, 1'b1, 4'hF, 12'h040, 32'h0);
        tick();
        tick();
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_i = 2'b11;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("mid_rst_ceb", 32'(mem_ceb), 32'd1);
        chk("mid_rst_locked", 32'(locked_o), 32'd0);
        chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
        sb.delete();
        ops[0].delete();
        ops[1].delete();
        gnt_log.delete();
        m_ptr = 0; m_locked = 1'b0; m_owner = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_i = '0;
        push_op(0, 1'b0, 1'b0, 4'hF, 12'h040, 32'h0);
        push_op(1, 1'b0, 1'b0, 4'hF, 12'h010, 32'h0);
        run_until_empty(20);
        chk_log("post_rst_order", 0, 1, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
